// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants, forwarding codes and the pipeline stage
//                record used by the hazard tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // An operand whose tuse is this value is not read by the instruction
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // ID-stage operand sources
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EX    = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    // EX-stage operand sources
    localparam logic [1:0] FWDX_PIPE = 2'b00;
    localparam logic [1:0] FWDX_MEM  = 2'b01;
    localparam logic [1:0] FWDX_WB   = 2'b10;

    // One pipeline stage worth of hazard bookkeeping
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_rec_t;

    // Saturating decrement: a result that already exists stays at zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hz_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : hz_stage_reg
//  Description : One stage record register with asynchronous clear, flush
//                clear and optional saturating tnew decrement on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_stage_reg
    import hazard_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  stage_rec_t d,
    output stage_rec_t q
);

    stage_rec_t w_next;

    // Age the incoming record by one cycle when it moves down the pipe
    always_comb begin
        w_next      = d;
        w_next.tnew = DEC_TNEW ? tnew_dec(d.tnew) : d.tnew;
    end

    // Record register; flush empties the slot like a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else begin
            q <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_tracker
//  Description : Tuse/Tnew hazard detection for a 5-stage MIPS-style pipe.
//                Tracks EX/MEM/WB producers, raises stall and selects the
//                forwarding source for ID, EX and MEM store data.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_tracker
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_a3,
    input  logic       id_we,
    input  logic [1:0] id_tnew,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_id,
    output logic [1:0] fwd_rt_id,
    output logic [1:0] fwd_rs_ex,
    output logic [1:0] fwd_rt_ex,
    output logic       fwd_rt_mem
);

    stage_rec_t w_ex_d;
    stage_rec_t r_ex;
    stage_rec_t r_mem;
    stage_rec_t r_wb;

    // Source fields of MEM/WB are never consulted for hazards
    logic w_unused;
    assign w_unused = ^{r_mem.rs, r_wb.rs, r_wb.rt};

    // A stage produces r only when it is a live writer of a nonzero register
    function automatic logic is_prod(input stage_rec_t s, input logic [4:0] r);
        return s.valid && s.we && (s.a3 == r) && (r != 5'd0);
    endfunction

    // Producer still in EX or MEM whose result arrives after the use point
    function automatic logic need_stall(input stage_rec_t ex, input stage_rec_t mem,
                                        input logic [4:0] r, input logic [1:0] tuse);
        logic late;
        late = 1'b0;
        if (tuse != TUSE_NONE) begin
            late = (is_prod(ex, r)  && (ex.tnew  > tuse)) ||
                   (is_prod(mem, r) && (mem.tnew > tuse));
        end
        return late;
    endfunction

    // Youngest producer wins; if its value is not ready, read RF (stall covers it)
    function automatic logic [1:0] sel_id(input stage_rec_t ex, input stage_rec_t mem,
                                          input stage_rec_t wb, input logic [4:0] r);
        logic [1:0] src;
        src = FWD_RF;
        if (is_prod(ex, r)) begin
            src = (ex.tnew == 2'd0) ? FWD_EX : FWD_RF;
        end else if (is_prod(mem, r)) begin
            src = (mem.tnew == 2'd0) ? FWD_MEM : FWD_RF;
        end else if (is_prod(wb, r)) begin
            src = (wb.tnew == 2'd0) ? FWD_WB : FWD_RF;
        end
        return src;
    endfunction

    // EX operand: ready MEM result first, then ready WB result
    function automatic logic [1:0] sel_ex(input stage_rec_t mem, input stage_rec_t wb,
                                          input logic [4:0] r);
        logic [1:0] src;
        src = FWDX_PIPE;
        if (is_prod(mem, r) && (mem.tnew == 2'd0)) begin
            src = FWDX_MEM;
        end else if (is_prod(wb, r) && (wb.tnew == 2'd0)) begin
            src = FWDX_WB;
        end
        return src;
    endfunction

    // Stall and forwarding decisions, all same-cycle combinational
    always_comb begin
        stall      = need_stall(r_ex, r_mem, id_rs, id_tuse_rs) ||
                     need_stall(r_ex, r_mem, id_rt, id_tuse_rt);
        fwd_rs_id  = sel_id(r_ex, r_mem, r_wb, id_rs);
        fwd_rt_id  = sel_id(r_ex, r_mem, r_wb, id_rt);
        fwd_rs_ex  = sel_ex(r_mem, r_wb, r_ex.rs);
        fwd_rt_ex  = sel_ex(r_mem, r_wb, r_ex.rt);
        fwd_rt_mem = is_prod(r_wb, r_mem.rt);
    end

    // EX captures the ID instruction, or a fully cleared bubble while stalled
    always_comb begin
        w_ex_d = '0;
        if (!stall) begin
            w_ex_d.valid = 1'b1;
            w_ex_d.we    = id_we;
            w_ex_d.a3    = id_a3;
            w_ex_d.tnew  = id_tnew;
            w_ex_d.rs    = id_rs;
            w_ex_d.rt    = id_rt;
        end
    end

    hz_stage_reg #(.DEC_TNEW(1'b0)) u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (w_ex_d),
        .q     (r_ex)
    );

    hz_stage_reg #(.DEC_TNEW(1'b1)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (r_ex),
        .q     (r_mem)
    );

    hz_stage_reg #(.DEC_TNEW(1'b1)) u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .d     (r_mem),
        .q     (r_wb)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_tracker
//  Description : Directed self-checking bench for hazard_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_tracker;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] id_tuse_rs;
    logic [1:0] id_tuse_rt;
    logic [4:0] id_a3;
    logic       id_we;
    logic [1:0] id_tnew;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rs_id;
    logic [1:0] fwd_rt_id;
    logic [1:0] fwd_rs_ex;
    logic [1:0] fwd_rt_ex;
    logic       fwd_rt_mem;

    int n_cmp = 0;
    int n_err = 0;

    hazard_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_a3      (id_a3),
        .id_we      (id_we),
        .id_tnew    (id_tnew),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_id  (fwd_rs_id),
        .fwd_rt_id  (fwd_rt_id),
        .fwd_rs_ex  (fwd_rs_ex),
        .fwd_rt_ex  (fwd_rt_ex),
        .fwd_rt_mem (fwd_rt_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID instruction: rs, rt, tuse_rs, tuse_rt, a3, we, tnew
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] urs, input logic [1:0] urt,
                          input logic [4:0] a3, input logic we, input logic [1:0] tn);
        id_rs = rs; id_rt = rt; id_tuse_rs = urs; id_tuse_rt = urt;
        id_a3 = a3; id_we = we; id_tnew = tn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(5'd8, 5'd9, 2'd0, 2'd0, 5'd8, 1'b1, 2'd2);
        tick();
        tick();
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++;
        if ({fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem} !== 9'd0) begin
            n_err++; $display("FAIL reset_fwd: got %b want 000000000",
                              {fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_load_use();
        set_id(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);   // lw $8
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL lu_first_stall: got %b want 0", stall); end
        tick();
        set_id(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 1'b1, 2'd1);   // add rs=$8
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL lu_unstall: got %b want 0", stall); end
        n_cmp++;
        if (fwd_rs_id !== 2'b00) begin n_err++; $display("FAIL lu_id_notready: got %b want 00", fwd_rs_id); end
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        n_cmp++;
        if (fwd_rs_ex !== 2'b10) begin n_err++; $display("FAIL lu_ex_wb: got %b want 10", fwd_rs_ex); end
        n_cmp++;
        if (fwd_rt_ex !== 2'b00) begin n_err++; $display("FAIL lu_ex_rt0: got %b want 00", fwd_rt_ex); end
        drain();
    endtask

    task automatic test_branch_alu();
        set_id(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd1);    // add $9
        tick();
        set_id(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);    // beq rs=$9
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL br_stall: got %b want 1", stall); end
        tick();
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL br_unstall: got %b want 0", stall); end
        n_cmp++;
        if (fwd_rs_id !== 2'b10) begin n_err++; $display("FAIL br_fwd_mem: got %b want 10", fwd_rs_id); end
        drain();
    endtask

    task automatic test_jal_link();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 1'b1, 2'd0);   // jal
        tick();
        set_id(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);   // jr $31
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL jal_stall: got %b want 0", stall); end
        n_cmp++;
        if (fwd_rs_id !== 2'b01) begin n_err++; $display("FAIL jal_fwd_ex: got %b want 01", fwd_rs_id); end
        drain();
    endtask

    task automatic test_store_data();
        set_id(5'd29, 5'd0, 2'd1, 2'd3, 5'd4, 1'b1, 2'd2);   // lw $4
        tick();
        set_id(5'd29, 5'd4, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);   // sw rt=$4
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL sw_stall: got %b want 0", stall); end
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        n_cmp++;
        if (fwd_rt_ex !== 2'b00) begin n_err++; $display("FAIL sw_ex_notready: got %b want 00", fwd_rt_ex); end
        tick();
        n_cmp++;
        if (fwd_rt_mem !== 1'b1) begin n_err++; $display("FAIL sw_mem_wb: got %b want 1", fwd_rt_mem); end
        drain();
        set_id(5'd29, 5'd0, 2'd1, 2'd3, 5'd0, 1'b1, 2'd2);   // lw $0
        tick();
        set_id(5'd29, 5'd0, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);   // sw rt=$0
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL sw0_stall: got %b want 0", stall); end
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        tick();
        n_cmp++;
        if (fwd_rt_mem !== 1'b0) begin n_err++; $display("FAIL sw0_mem: got %b want 0", fwd_rt_mem); end
        drain();
    endtask

    task automatic test_priority();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd0);    // A writes $5
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd0);    // B writes $5
        tick();
        set_id(5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);    // C reads $5
        n_cmp++;
        if (fwd_rs_id !== 2'b01) begin n_err++; $display("FAIL pri_rs_ex: got %b want 01", fwd_rs_id); end
        n_cmp++;
        if (fwd_rt_id !== 2'b01) begin n_err++; $display("FAIL pri_rt_ex: got %b want 01", fwd_rt_id); end
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL pri_stall: got %b want 0", stall); end
        tick();
        set_id(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);    // D reads $5
        n_cmp++;
        if (fwd_rs_ex !== 2'b01) begin n_err++; $display("FAIL pri_exfwd_mem: got %b want 01", fwd_rs_ex); end
        n_cmp++;
        if (fwd_rt_ex !== 2'b01) begin n_err++; $display("FAIL pri_exfwd_rt: got %b want 01", fwd_rt_ex); end
        n_cmp++;
        if (fwd_rs_id !== 2'b10) begin n_err++; $display("FAIL pri_id_mem: got %b want 10", fwd_rs_id); end
        tick();
        n_cmp++;
        if (fwd_rs_id !== 2'b11) begin n_err++; $display("FAIL pri_id_wb: got %b want 11", fwd_rs_id); end
        n_cmp++;
        if (fwd_rs_ex !== 2'b10) begin n_err++; $display("FAIL pri_exfwd_wb: got %b want 10", fwd_rs_ex); end
        drain();
    endtask

    task automatic test_flush();
        set_id(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);   // lw $8
        tick();
        set_id(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 1'b1, 2'd1);   // add rs=$8
        flush = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall: got %b want 1", stall); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", stall); end
        n_cmp++;
        if ({fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem} !== 9'd0) begin
            n_err++; $display("FAIL fl_fwd: got %b want 000000000",
                              {fwd_rs_id, fwd_rt_id, fwd_rs_ex, fwd_rt_ex, fwd_rt_mem});
        end
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        n_cmp++;
        if (fwd_rs_ex !== 2'b00) begin n_err++; $display("FAIL fl_no_stale: got %b want 00", fwd_rs_ex); end
        drain();
    endtask

    task automatic test_async_reset();
        set_id(5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2);   // lw $8
        tick();
        set_id(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 1'b1, 2'd1);   // add rs=$8
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL ar_pre_stall: got %b want 1", stall); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL ar_async_stall: got %b want 0", stall); end
        #1;
        rst_n = 1'b1;
        tick();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL ar_post_stall: got %b want 0", stall); end
        tick();
        n_cmp++;
        if (fwd_rs_ex !== 2'b00) begin n_err++; $display("FAIL ar_no_stale: got %b want 00", fwd_rs_ex); end
        drain();
    endtask

    task automatic test_reg0();
        set_id(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd2);    // writes $0
        tick();
        set_id(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall: got %b want 0", stall); end
        n_cmp++;
        if ({fwd_rs_id, fwd_rt_id} !== 4'd0) begin
            n_err++; $display("FAIL r0_fwd: got %b want 0000", {fwd_rs_id, fwd_rt_id});
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_alu();
        test_jal_link();
        test_store_data();
        test_priority();
        test_flush();
        test_async_reset();
        test_reg0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL have `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have `id_rs`, `id_rt`, input, 5 bits each: source register numbers of the instruction in ID.
REQ-004 The block SHALL have `id_tuse_rs`, `id_tuse_rt`, input, 2 bits each: cycles until the ID instruction needs the operand; 0 = ID, 1 = EX, 2 = MEM, 3 = unused.
REQ-005 The block SHALL have `id_a3`, input, 5 bits: destination register of the ID instruction.
REQ-006 The block SHALL have `id_we`, input, 1 bit: the ID instruction writes the register file.
REQ-007 The block SHALL have `id_tnew`, input, 2 bits: cycles after EX entry until the result exists; 0 = link value, 1 = ALU result, 2 = load.
REQ-008 The block SHALL have `flush`, input, 1 bit: exception or eret; invalidates EX, MEM and WB at the next edge.
REQ-009 The block SHALL have `stall`, output, 1 bit: freeze PC and IF/ID, and insert a bubble into EX.
REQ-010 The block SHALL have `fwd_rs_id`, `fwd_rt_id`, output, 2 bits each: ID operand source; 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
REQ-011 The block SHALL have `fwd_rs_ex`, `fwd_rt_ex`, output, 2 bits each: EX operand source; 00 = pipeline register, 01 = MEM, 10 = WB.
REQ-012 The block SHALL have `fwd_rt_mem`, output, 1 bit: MEM store data is taken from WB.

Function
REQ-013 The block SHALL hold three stage records, EX, MEM and WB, each containing {valid, we, a3, tnew, rs, rt}.
REQ-014 On each clock edge with flush=0, the records SHALL advance as follows:
- EX <= ID fields, or a bubble (valid=0) when stall=1.
- MEM <= EX with tnew = max(tnew-1, 0).
- WB <= MEM with tnew = max(tnew-1, 0).
REQ-015 A stage SHALL be a producer for register r only when valid=1, we=1, a3==r and r!=0.
REQ-016 `stall` SHALL be 1 when, for an operand with tuse!=3, the EX or MEM producer has tnew > tuse; it SHALL be combinational in the same cycle.
REQ-017 ID forwarding SHALL select the youngest producer among EX, MEM and WB whose tnew==0.
- If the youngest producer has tnew>0, the output SHALL be 00; stall covers that case.
REQ-018 EX forwarding SHALL use the EX-record rs and rt against MEM and then WB producers with tnew==0, MEM first.
REQ-019 `fwd_rt_mem` SHALL be 1 when the MEM record rt has a WB producer.
REQ-020 Register 0 SHALL never stall or forward.
REQ-021 flush=1 SHALL clear valid in all three records at the next edge; flush SHALL take priority over stall.
REQ-022 Simultaneous stall and ID producer: the bubble SHALL be inserted and MEM/WB SHALL still advance.
REQ-023 All outputs SHALL be purely combinational from state plus ID inputs, with no added latency.

Reset
REQ-024 rst_n=0 SHALL immediately clear valid, we, a3, tnew, rs and rt in all records, independent of clk.
REQ-025 While reset is asserted, stall SHALL be 0 and all fwd outputs SHALL be 0.
REQ-026 Reset deassertion mid-stream SHALL leave the pipeline empty; no stale forwarding SHALL occur.

Structure
REQ-027 Package `hazard_pkg` SHALL hold:
- constant TUSE_NONE = 3;
- ID forwarding codes FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
- EX forwarding codes;
- the stage record typedef.
REQ-028 A single sub-module, `hz_stage_reg`, SHALL be instantiated three times. Each instance implements one record register with async clear, flush clear and saturating tnew decrement.
REQ-029 Matching and priority logic SHALL live in the top level only.

Verification
REQ-030 Load-use: ID lw $8 (tnew=2, we); next cycle ID add rs=$8 (tuse=1).
- Expected: stall=1 for one cycle, then fwd_rs_ex=10 (WB) in the following EX cycle.
REQ-031 Branch after ALU: add $9 in EX (tnew=1), ID beq rs=$9 (tuse=0).
- Expected: stall=1 for one cycle, then fwd_rs_id=10 (MEM).
REQ-032 jal link: jal in EX (a3=31, tnew=0), ID jr $31.
- Expected: stall=0 and fwd_rs_id=01.
REQ-033 Store data: lw $4 in WB and sw rt=$4 in MEM.
- Expected: fwd_rt_mem=1; with rt=$0 the result SHALL be 0.
REQ-034 Priority: EX and MEM both write $5 with tnew=0.
- Expected: fwd_rs_id=01 (EX wins).
REQ-035 flush with stall=1 and async reset mid-stall.
- Expected: the next cycle shows all records invalid, stall=0 and all fwd outputs=0.
